// File: rtl/rtc_pkg.sv
// Shared widths and BCD digit limits for the RTC time-of-day core.
package rtc_pkg;
  localparam int BCD_W             = 4;
  localparam int SEC_MAX_HI        = 5;
  localparam int MIN_MAX_HI        = 5;
  localparam int HOUR_MAX_HI       = 2;
  localparam int HOUR_MAX_LO_AT_HI = 3;
  localparam int UNITS_MAX         = 9;

  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/rtc_timekeeper_bcd_pair_counter.sv
// Two-digit BCD counter (tens/units) that wraps to 00 at MAX_HI:MAX_LO_AT_MAX_HI.
module bcd_pair_counter
  import rtc_pkg::*;
#(
  parameter int MAX_HI           = 5,
  parameter int MAX_LO_AT_MAX_HI = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] hi_o,
  output logic [BCD_W-1:0] lo_o,
  output logic             carry_o
);
  bcd_t r_hi, r_lo;
  logic w_at_max, w_lo_wrap;

  assign w_at_max  = (r_hi == BCD_W'(MAX_HI)) && (r_lo == BCD_W'(MAX_LO_AT_MAX_HI));
  assign w_lo_wrap = (r_lo == BCD_W'(UNITS_MAX));
  assign carry_o   = inc_i & w_at_max;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (inc_i) begin
      if (w_at_max) begin
        r_hi <= '0;
        r_lo <= '0;
      end else if (w_lo_wrap) begin
        r_hi <= r_hi + BCD_W'(1);
        r_lo <= '0;
      end else begin
        r_lo <= r_lo + BCD_W'(1);
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;
endmodule

// File: rtl/rtc_timekeeper.sv
// RTC time-of-day core: 1 Hz prescaler plus HH:MM:SS in packed BCD, with push-button time set.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_mode_i,
  input  logic             inc_min_i,
  input  logic             inc_hour_i,
  output logic [BCD_W-1:0] min_lo_o,
  output logic [BCD_W-1:0] min_hi_o,
  output logic [BCD_W-1:0] hour_lo_o,
  output logic [BCD_W-1:0] hour_hi_o,
  output logic             sec_o,
  output logic             sec_tick_o
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_min_prev, r_hour_prev;
  logic          r_armed;

  logic       w_tick;
  logic       w_min_edge, w_hour_edge;
  logic       w_sec_carry, w_min_carry;
  logic       w_min_inc, w_hour_inc;
  bcd_t       w_sec_lo, w_unused_sec_hi;
  logic       w_unused_hour_carry;

  assign w_tick = ~set_mode_i & (r_presc == PRESC_LAST);

  // r_armed masks the first cycle after reset so a button held through reset never fires.
  assign w_min_edge  = set_mode_i & r_armed & inc_min_i  & ~r_min_prev;
  assign w_hour_edge = set_mode_i & r_armed & inc_hour_i & ~r_hour_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_min_prev  <= 1'b0;
      r_hour_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      if (set_mode_i || w_tick) r_presc <= '0;
      else                      r_presc <= r_presc + PW'(1);
      r_tick      <= w_tick;
      r_min_prev  <= inc_min_i;
      r_hour_prev <= inc_hour_i;
      r_armed     <= 1'b1;
    end
  end

  // In set mode a minute wrap must not reach the hours.
  assign w_min_inc  = w_sec_carry | w_min_edge;
  assign w_hour_inc = (w_min_carry & ~set_mode_i) | w_hour_edge;

  bcd_pair_counter #(.MAX_HI(SEC_MAX_HI), .MAX_LO_AT_MAX_HI(UNITS_MAX)) u_sec (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (set_mode_i),
    .inc_i   (w_tick),
    .hi_o    (w_unused_sec_hi),
    .lo_o    (w_sec_lo),
    .carry_o (w_sec_carry)
  );

  bcd_pair_counter #(.MAX_HI(MIN_MAX_HI), .MAX_LO_AT_MAX_HI(UNITS_MAX)) u_min (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (w_min_inc),
    .hi_o    (min_hi_o),
    .lo_o    (min_lo_o),
    .carry_o (w_min_carry)
  );

  bcd_pair_counter #(.MAX_HI(HOUR_MAX_HI), .MAX_LO_AT_MAX_HI(HOUR_MAX_LO_AT_HI)) u_hour (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (w_hour_inc),
    .hi_o    (hour_hi_o),
    .lo_o    (hour_lo_o),
    .carry_o (w_unused_hour_carry)
  );

  assign sec_o      = w_sec_lo[0];
  assign sec_tick_o = r_tick;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with an arithmetic time-of-day reference model.
module tb_rtc_timekeeper;
  localparam int CLK_HZ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_mode = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
  logic [3:0] min_lo, min_hi, hour_lo, hour_hi;
  logic sec, sec_tick;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // reference model state: plain integers for h/m/s
  int m_h = 0, m_m = 0, m_s = 0, m_pc = 0;
  bit m_tick = 0, m_pmin = 0, m_phour = 0, m_armed = 0;

  rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_mode_i (set_mode),
    .inc_min_i  (inc_min),
    .inc_hour_i (inc_hour),
    .min_lo_o   (min_lo),
    .min_hi_o   (min_hi),
    .hour_lo_o  (hour_lo),
    .hour_hi_o  (hour_hi),
    .sec_o      (sec),
    .sec_tick_o (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int h, m, s, pc, t;
    bit tk, emin, ehr;
    h = m_h; m = m_m; s = m_s; pc = m_pc; tk = 0;
    if (rst) begin
      h = 0; m = 0; s = 0; pc = 0;
      m_pmin <= 0; m_phour <= 0; m_armed <= 0;
    end else begin
      emin = m_armed && inc_min  && !m_pmin;
      ehr  = m_armed && inc_hour && !m_phour;
      if (set_mode) begin
        pc = 0; s = 0;
        if (emin) m = (m + 1) % 60;
        if (ehr)  h = (h + 1) % 24;
      end else begin
        tk = (pc == CLK_HZ - 1);
        pc = tk ? 0 : pc + 1;
        if (tk) begin
          t = (h * 3600 + m * 60 + s + 1) % 86400;
          h = t / 3600; m = (t / 60) % 60; s = t % 60;
        end
      end
      m_pmin <= inc_min; m_phour <= inc_hour; m_armed <= 1;
    end
    m_h <= h; m_m <= m; m_s <= s; m_pc <= pc; m_tick <= tk;
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model", {14'd0, hour_hi, hour_lo, min_hi, min_lo, sec, sec_tick},
            {14'd0, 4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 1'(m_s % 2), m_tick});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit mn, input bit hr, input int n);
    repeat (n) begin
      inc_min = mn; inc_hour = hr; cyc(1);
      inc_min = 0;  inc_hour = 0;  cyc(1);
    end
  endtask

  task automatic check_time(input string nm, input logic [15:0] hhmm);
    check(nm, {16'd0, hour_hi, hour_lo, min_hi, min_lo}, {16'd0, hhmm});
  endtask

  initial begin
    cyc(2);
    check_time("reset_time", 16'h0000);
    check("reset_sec", {30'd0, sec, sec_tick}, 32'd0);
    rst = 0; chk_en = 1;

    // first tick: prescaler wraps in cycle 3, registered output in cycle 4
    cyc(3);
    check("pre_tick", sec_tick, 0);
    cyc(1);
    check("tick1", sec_tick, 1);
    check("sec_o_1", sec, 1);
    check("model_s1", m_s, 1);
    cyc(1);
    check("tick_one_cycle", sec_tick, 0);
    cyc(3);
    check("sec_o_2", sec, 0);

    // preload 23:59 then run to 23:59:58
    set_mode = 1;
    press(1, 1, 23);
    press(1, 0, 36);
    check_time("preload", 16'h2359);
    set_mode = 0;
    cyc(232);
    check_time("t_235958", 16'h2359);
    check("model_s58", m_s, 58);
    cyc(4);
    check_time("t_235959", 16'h2359);
    check("sec_o_59", sec, 1);
    cyc(4);
    check_time("t_000000", 16'h0000);
    check("midnight", {30'd0, sec, sec_tick}, 32'd1);

    // set mode wrap rules
    set_mode = 1;
    press(1, 0, 59);
    check_time("set_0059", 16'h0059);
    press(1, 0, 1);
    check_time("min_wrap_nocarry", 16'h0000);
    press(0, 1, 23);
    check_time("set_2300", 16'h2300);
    press(0, 1, 1);
    check_time("hour_wrap", 16'h0000);

    // simultaneous edges at 12:34
    press(0, 1, 12);
    press(1, 0, 34);
    check_time("set_1234", 16'h1234);
    inc_min = 1; inc_hour = 1; cyc(1);
    check_time("both_edges", 16'h1335);
    cyc(10);
    check_time("both_held", 16'h1335);
    inc_min = 0; inc_hour = 0; cyc(1);

    // reach 23:59:59 then reset in the carry cycle
    press(0, 1, 10);
    press(1, 0, 24);
    check_time("set_2359", 16'h2359);
    set_mode = 0;
    cyc(236);
    check("model_s59", m_s, 59);
    cyc(3);
    rst = 1; inc_min = 1; set_mode = 1;
    cyc(1);
    check_time("rst_carry_time", 16'h0000);
    check("rst_carry_sec", {30'd0, sec, sec_tick}, 32'd0);
    rst = 0;
    cyc(3);
    check_time("held_through_rst", 16'h0000);
    inc_min = 0; set_mode = 0; cyc(1);

    // edges ignored in run mode
    press(1, 1, 5);
    check_time("run_edges_ignored", 16'h0000);

    // enter set mode at seconds 37
    rst = 1; cyc(1); rst = 0;
    cyc(148);
    check("model_s37", m_s, 37);
    check("sec_o_37", sec, 1);
    set_mode = 1; cyc(1);
    check("set_clears_sec", sec, 0);
    check("model_s0", m_s, 0);
    cyc(10);
    check("frozen", {30'd0, sec, sec_tick}, 32'd0);
    set_mode = 0;
    cyc(3);
    check("restart_no_tick", sec_tick, 0);
    cyc(1);
    check("restart_tick", {30'd0, sec, sec_tick}, 32'd3);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Time-of-day core for the RTC: divides clk_i down to a 1 Hz tick and keeps HH:MM:SS as packed BCD.
- Feeds the 4-digit 7-segment display driver directly downstream:
  - four BCD nibbles drive digit sign0..sign3 (sign0 = minute units … sign3 = hour tens);
  - sec_o drives the blinking colon, via seconds parity.
- Time is set by push-button inputs. Button edges are detected here; debouncing is done upstream.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency. The prescaler wraps every CLK_HZ cycles. Legal range is 2 or greater.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- set_mode_i  in  1  level. 1 = time-set mode: clock halted, buttons active.
- inc_min_i  in  1  debounced button level; a rising edge increments minutes
- inc_hour_i  in  1  debounced button level; a rising edge increments hours
- min_lo_o  out  4  BCD minute units (display sign0)
- min_hi_o  out  4  BCD minute tens (sign1)
- hour_lo_o  out  4  BCD hour units (sign2)
- hour_hi_o  out  4  BCD hour tens (sign3)
- sec_o  out  1  LSB of the seconds units digit (display colon blink)
- sec_tick_o  out  1  one-cycle pulse on every counted second

Behaviour:
- Reset (rst_i = 1, sampled on posedge clk_i):
  - prescaler = 0, time = 00:00:00;
  - all outputs 0, sec_tick_o = 0;
  - edge-detect registers = 0, so a button held through reset does not increment when reset is released.
  - Reset overrides every other input, including mid-set and mid-carry.
- Prescaler:
  - width ceil(log2(CLK_HZ));
  - counts 0..CLK_HZ-1 while set_mode_i = 0;
  - on reaching CLK_HZ-1 it wraps to 0 and asserts the internal tick for that cycle.
- Run mode (set_mode_i = 0):
  - On a tick, seconds increment, registered. New values appear on the outputs the cycle after the tick cycle, and sec_tick_o pulses in that same cycle.
  - Seconds wrap 59 -> 00 and carry into minutes in the same update.
  - Minutes wrap 59 -> 00 and carry into hours in the same update.
  - Hours wrap 23 -> 00. No day output.
  - Ripple is fully combinational within one update: 23:59:59 -> 00:00:00 in a single step.
- Set mode (set_mode_i = 1):
  - prescaler held at 0, seconds forced to 00, sec_tick_o = 0.
  - inc_min_i rising edge: minutes +1, wrapping 59 -> 00 with NO carry into hours.
  - inc_hour_i rising edge: hours +1, wrapping 23 -> 00.
  - Both edges in the same cycle: both increments are applied.
  - Edge detection is 1 cycle (registered previous level). The result is visible on the outputs the cycle after the edge is sampled.
- Mode transitions:
  - Leaving set mode restarts counting from prescaler 0, so the first tick comes CLK_HZ cycles later.
  - Button edges are ignored in run mode. Edge registers keep tracking in both modes, so a button held across a mode change does not fire.
- BCD rules:
  - Each digit is 4 bits. Units roll 9 -> 0 with a carry into tens.
  - Tens limits: seconds and minutes tens ≤ 5; hours tens ≤ 2, with the 23 -> 00 rule checked on the full pair.
  - Illegal BCD is unreachable from reset and need not be handled.
- sec_o = seconds units[0]. It toggles every second in run mode and is 0 in set mode.

Decomposition:
- rtc_pkg holds:
  - BCD_W = 4;
  - limits SEC_MAX_HI = 5, MIN_MAX_HI = 5, HOUR_MAX_HI = 2, HOUR_MAX_LO_AT_HI = 3, UNITS_MAX = 9.
- Sub-module bcd_pair_counter:
  - parameters MAX_HI, MAX_LO_AT_MAX_HI;
  - ports clk_i, rst_i, inc_i, hi_o, lo_o, carry_o (combinational, asserted when inc_i and at max);
  - one instance each for seconds, minutes and hours. Seconds use a clear input in set mode; minutes take inc = tick-carry OR set-mode edge.

Test Plan (CLK_HZ = 4):
- Reset release, run 4 cycles -> sec_tick_o pulses once at cycle 4 (prescaler wrap cycle 3, registered), seconds = 01, sec_o = 1. After 4 more cycles -> sec_o = 0.
- Preload 23:59:58 via set mode, run 8 cycles -> outputs step 23:59:59 then 00:00:00 (hour_hi = 0, hour_lo = 0, min = 00) in single updates.
- set_mode_i = 1 at 00:59: inc_min_i edge -> 00:00 with hours unchanged. inc_hour_i edge at hour 23 -> 00.
- inc_min_i and inc_hour_i rise in the same cycle at 12:34 -> 13:35 next cycle. Holding both high for 10 cycles gives no further change.
- rst_i asserted during a 23:59:59 -> 00:00:00 carry cycle -> next cycle all outputs 0, no sec_tick_o. Button held high across reset release gives no increment.
- inc_min_i edges while set_mode_i = 0 -> ignored. Set mode entered at seconds 37 -> seconds 00 next cycle, sec_o = 0, prescaler frozen.
